// File: rtl/fixed_isqrt_arbiter.sv
// Round-robin arbiter sharing one fixed_isqrt pipeline among N_REQ requesters.
// An in-order tag FIFO routes each pipeline result back to the requester that issued it.
module fixed_isqrt_arbiter #(
  parameter int N_REQ        = 4,
  parameter int IN_WIDTH     = 16,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ*2*IN_WIDTH-1:0]       req_data,
  input  logic [N_REQ-1:0]                  req_valid,
  output logic [N_REQ-1:0]                  req_ready,
  output logic [N_REQ*2*IN_WIDTH-1:0]       resp_data,
  output logic [N_REQ-1:0]                  resp_valid,
  input  logic [N_REQ-1:0]                  resp_ready,
  output logic [2*IN_WIDTH-1:0]             isqrt_in_data,
  output logic                              isqrt_in_valid,
  input  logic                              isqrt_in_ready,
  input  logic [2*IN_WIDTH-1:0]             isqrt_out_data,
  input  logic                              isqrt_out_valid,
  output logic                              isqrt_out_ready,
  output logic [$clog2(MAX_INFLIGHT):0]     inflight,
  output logic                              err
);

  localparam int ID_WIDTH = $clog2(N_REQ);
  localparam int DW       = 2*IN_WIDTH;
  localparam int PW       = $clog2(MAX_INFLIGHT);
  localparam int CW       = PW + 1;
  localparam logic [ID_WIDTH-1:0] LAST_RST = ID_WIDTH'(N_REQ-1);
  localparam logic [CW-1:0]       FULL_CNT = CW'(MAX_INFLIGHT);

  logic [ID_WIDTH-1:0] last_r;
  logic [ID_WIDTH-1:0] tag_mem_r [MAX_INFLIGHT];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [CW-1:0]       inflight_r;
  logic                err_r;

  logic [ID_WIDTH-1:0] grant_s;
  logic [ID_WIDTH-1:0] head_id_s;
  logic                can_issue_s;
  logic                issue_s;
  logic                nonempty_s;
  logic                ret_s;
  logic                spurious_s;

  // Requester id that sits `step` places after `base` in the circular order.
  function automatic logic [ID_WIDTH-1:0] rr_id(input logic [ID_WIDTH-1:0] base, input int step);
    int sum;
    sum = (int'(base) + step) % N_REQ;
    return ID_WIDTH'(sum);
  endfunction

  // Round-robin grant: scanned farthest-first so the nearest valid requester after last_r wins.
  always_comb begin
    grant_s = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      grant_s = req_valid[rr_id(last_r, k)] ? rr_id(last_r, k) : grant_s;
    end
  end

  // Issue handshake towards the shared pipeline; a full FIFO blocks issue even if it pops this cycle.
  always_comb begin
    can_issue_s    = (|req_valid) && (inflight_r < FULL_CNT) && !rst;
    issue_s        = can_issue_s && isqrt_in_ready;
    isqrt_in_valid = can_issue_s;
    isqrt_in_data  = req_data[DW-1:0];
    req_ready      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (can_issue_s && (grant_s == ID_WIDTH'(i))) begin
        isqrt_in_data = req_data[i*DW +: DW];
        req_ready[i]  = isqrt_in_ready;
      end else begin
        req_ready[i]  = 1'b0;
      end
    end
  end

  // Return routing: the FIFO head owns the current pipeline result and may stall it.
  always_comb begin
    nonempty_s      = (inflight_r != '0) && !rst;
    head_id_s       = tag_mem_r[rd_ptr_r];
    isqrt_out_ready = nonempty_s && resp_ready[head_id_s];
    ret_s           = isqrt_out_valid && isqrt_out_ready;
    spurious_s      = isqrt_out_valid && (inflight_r == '0);
    resp_valid      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      resp_valid[i] = isqrt_out_valid && nonempty_s && (head_id_s == ID_WIDTH'(i));
    end
  end

  assign resp_data = {N_REQ{isqrt_out_data}};
  assign inflight  = inflight_r;
  assign err       = err_r;

  // Control state: round-robin pointer, FIFO pointers, occupancy and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r     <= LAST_RST;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      inflight_r <= '0;
      err_r      <= 1'b0;
    end else begin
      if (issue_s) begin
        last_r   <= grant_s;
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (ret_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({issue_s, ret_s})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
      if (spurious_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset: entries are only read while inflight_r is non-zero.
  always_ff @(posedge clk) begin
    if (issue_s) begin
      tag_mem_r[wr_ptr_r] <= grant_s;
    end
  end

endmodule

// File: tb/tb_fixed_isqrt_arbiter.sv
// Self-checking bench for fixed_isqrt_arbiter: a queue-based reference model checked every
// cycle, a vector table for arbitration order, and directed multi-cycle corner sequences.
module tb_fixed_isqrt_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int MAX = 8;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [N*DW-1:0] resp_data;
  logic [DW-1:0]   isqrt_in_data, isqrt_out_data;
  logic            isqrt_in_valid, isqrt_in_ready, isqrt_out_valid, isqrt_out_ready;
  logic [3:0]      inflight;
  logic            err;

  fixed_isqrt_arbiter #(.N_REQ(N), .IN_WIDTH(16), .MAX_INFLIGHT(MAX)) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .isqrt_in_data(isqrt_in_data), .isqrt_in_valid(isqrt_in_valid), .isqrt_in_ready(isqrt_in_ready),
    .isqrt_out_data(isqrt_out_data), .isqrt_out_valid(isqrt_out_valid), .isqrt_out_ready(isqrt_out_ready),
    .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stand-in for the isqrt datapath: any fixed function lets routing be verified end to end.
  function automatic logic [31:0] pipe_fn(input logic [31:0] x);
    return (x * 32'd3) ^ 32'h0F0F_1234;
  endfunction

  typedef struct { logic [31:0] data; int due; } pipe_t;
  typedef struct { logic [3:0] rv; logic in_rdy; logic [3:0] exp_rr; logic exp_iv; } vec_t;

  int          m_last;
  int          m_tags[$];
  logic [31:0] m_exp[$];
  bit          m_err;
  pipe_t       pipe_q[$];
  int          cyc;
  bit          spur;

  logic [N-1:0]    s_req_ready, s_resp_valid;
  logic [N*DW-1:0] s_resp_data;
  logic            s_in_valid, s_oready, s_err;
  int              s_inflight;

  task automatic run_cycle();
    int          e_grant, e_head;
    bit          e_can, e_iss, e_ne, e_oready, e_ret, dut_iss, dut_ret;
    logic [N-1:0] e_rr, e_rv;
    logic [31:0] e_slice, dut_in;
    pipe_t       p;
    if (spur) begin
      isqrt_out_valid = 1'b1; isqrt_out_data = 32'hDEAD_BEEF;
    end else if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
      isqrt_out_valid = 1'b1; isqrt_out_data = pipe_q[0].data;
    end else begin
      isqrt_out_valid = 1'b0; isqrt_out_data = 32'h0;
    end
    #3;
    e_grant = -1;
    for (int k = 1; k <= N; k++)
      if (e_grant < 0 && req_valid[(m_last + k) % N]) e_grant = (m_last + k) % N;
    e_can    = !rst && e_grant >= 0 && m_tags.size() < MAX;
    e_iss    = e_can && isqrt_in_ready;
    e_ne     = !rst && m_tags.size() != 0;
    e_head   = (m_tags.size() != 0) ? m_tags[0] : 0;
    e_oready = e_ne && resp_ready[e_head];
    e_ret    = e_oready && isqrt_out_valid;
    e_rr = '0; if (e_iss) e_rr[e_grant] = 1'b1;
    e_rv = '0; if (e_ne && isqrt_out_valid) e_rv[e_head] = 1'b1;
    e_slice = req_data[DW-1:0];
    if (e_can) e_slice = req_data[e_grant*DW +: DW];
    chk("in_valid", isqrt_in_valid, e_can);
    chk("req_ready", req_ready, e_rr);
    chk("in_data", isqrt_in_data, e_slice);
    chk("resp_valid", resp_valid, e_rv);
    chk("out_ready", isqrt_out_ready, e_oready);
    chk("inflight", inflight, m_tags.size());
    chk("err", err, m_err);
    if (e_ret) chk("resp_data", resp_data[e_head*DW +: DW], m_exp[0]);
    s_req_ready = req_ready; s_resp_valid = resp_valid; s_resp_data = resp_data;
    s_in_valid = isqrt_in_valid; s_oready = isqrt_out_ready; s_err = err; s_inflight = int'(inflight);
    dut_iss = isqrt_in_valid && isqrt_in_ready;
    dut_ret = isqrt_out_valid && isqrt_out_ready;
    dut_in  = isqrt_in_data;
    @(posedge clk);
    if (rst) begin
      m_tags.delete(); m_exp.delete(); pipe_q.delete();
      m_last = N - 1; m_err = 1'b0;
    end else begin
      if (isqrt_out_valid && !e_ne) m_err = 1'b1;
      if (e_ret) begin void'(m_tags.pop_front()); void'(m_exp.pop_front()); end
      if (e_iss) begin m_tags.push_back(e_grant); m_exp.push_back(pipe_fn(e_slice)); m_last = e_grant; end
      if (dut_ret && !spur && pipe_q.size() > 0) void'(pipe_q.pop_front());
      if (dut_iss) begin p.data = pipe_fn(dut_in); p.due = cyc + LAT; pipe_q.push_back(p); end
    end
    cyc++;
    #1;
  endtask

  task automatic reset_cycle();
    rst = 1'b1; run_cycle(); rst = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid = '0; resp_ready = '1; isqrt_in_ready = 1'b1;
    repeat (n) run_cycle();
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{4'b0010, 1'b1, 4'b0010, 1'b1};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0100, 1'b1};
    vecs[2]  = '{4'b1111, 1'b1, 4'b1000, 1'b1};
    vecs[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0010, 1'b1};
    vecs[5]  = '{4'b1001, 1'b0, 4'b0000, 1'b1};
    vecs[6]  = '{4'b1001, 1'b1, 4'b1000, 1'b1};
    vecs[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0};
    vecs[8]  = '{4'b0011, 1'b1, 4'b0001, 1'b1};
    vecs[9]  = '{4'b0101, 1'b1, 4'b0100, 1'b1};
    vecs[10] = '{4'b0101, 1'b1, 4'b0001, 1'b1};
    vecs[11] = '{4'b0001, 1'b1, 4'b0001, 1'b1};

    rst = 1'b1; req_valid = '0; req_data = '0; isqrt_in_ready = 1'b1; resp_ready = '1;
    isqrt_out_valid = 1'b0; isqrt_out_data = '0; spur = 1'b0;
    m_last = N - 1; m_err = 1'b0; cyc = 0;
    @(posedge clk); #1;
    run_cycle();
    req_valid = '1;
    run_cycle();
    chk("rst_in_valid", s_in_valid, 1'b0);
    chk("rst_req_ready", s_req_ready, 4'b0000);
    chk("rst_inflight", s_inflight, 0);
    rst = 1'b0; req_valid = '0;

    // single requester, 4.0 in Q.7
    req_data = '0; req_data[1*DW +: DW] = 32'h0000_0200; req_valid = 4'b0010;
    run_cycle();
    chk("single_ready", s_req_ready, 4'b0010);
    chk("single_inflight0", s_inflight, 0);
    req_valid = '0;
    run_cycle();
    chk("single_inflight1", s_inflight, 1);
    run_cycle();
    run_cycle();
    chk("single_resp_valid", s_resp_valid, 4'b0010);
    chk("single_resp_data", s_resp_data[1*DW +: DW], pipe_fn(32'h0000_0200));
    run_cycle();
    chk("single_inflight_end", s_inflight, 0);

    // arbitration vectors from reset state
    reset_cycle();
    for (int v = 0; v < 12; v++) begin
      req_data = {$urandom, $urandom, $urandom, $urandom};
      req_valid = vecs[v].rv; isqrt_in_ready = vecs[v].in_rdy;
      run_cycle();
      chk($sformatf("vec%0d_req_ready", v), s_req_ready, vecs[v].exp_rr);
      chk($sformatf("vec%0d_in_valid", v), s_in_valid, vecs[v].exp_iv);
    end
    drain(6);

    // fairness: 0,1,2,3,0,1,2,3
    reset_cycle();
    req_valid = '1;
    for (int t = 0; t < 8; t++) begin
      req_data = {$urandom, $urandom, $urandom, $urandom};
      run_cycle();
      chk($sformatf("fair%0d", t), s_req_ready, 4'b0001 << (t % 4));
    end
    drain(6);

    // full FIFO with stalled responses
    reset_cycle();
    resp_ready = '0; req_valid = '1;
    for (int t = 0; t < 8; t++) begin
      req_data = {$urandom, $urandom, $urandom, $urandom};
      run_cycle();
      chk($sformatf("fill%0d_in_valid", t), s_in_valid, 1'b1);
    end
    run_cycle();
    chk("full_inflight", s_inflight, 8);
    chk("full_in_valid", s_in_valid, 1'b0);
    resp_ready = '1;
    run_cycle();
    chk("full_pop_oready", s_oready, 1'b1);
    chk("full_pop_no_issue", s_in_valid, 1'b0);
    run_cycle();
    chk("full_resume_inflight", s_inflight, 7);
    chk("full_resume_in_valid", s_in_valid, 1'b1);
    drain(14);

    // head-of-line: tags 2 then 0, requester 2 stalled
    reset_cycle();
    resp_ready = 4'b0001;
    req_data = {$urandom, $urandom, $urandom, $urandom};
    req_valid = 4'b0100; run_cycle();
    req_valid = 4'b0001; run_cycle();
    req_valid = '0;
    repeat (3) run_cycle();
    chk("hol_resp_valid", s_resp_valid, 4'b0100);
    chk("hol_oready", s_oready, 1'b0);
    resp_ready = '1;
    run_cycle();
    chk("hol_ret2_valid", s_resp_valid, 4'b0100);
    chk("hol_ret2_oready", s_oready, 1'b1);
    run_cycle();
    chk("hol_ret0_valid", s_resp_valid, 4'b0001);
    chk("hol_ret0_oready", s_oready, 1'b1);
    run_cycle();
    chk("hol_inflight_end", s_inflight, 0);

    // spurious result
    spur = 1'b1; run_cycle(); spur = 1'b0;
    chk("spur_oready", s_oready, 1'b0);
    chk("spur_err_before", s_err, 1'b0);
    run_cycle();
    chk("spur_err_set", s_err, 1'b1);
    run_cycle();
    chk("spur_err_held", s_err, 1'b1);
    reset_cycle();
    run_cycle();
    chk("spur_err_cleared", s_err, 1'b0);

    // reset with three tags outstanding
    resp_ready = '0; req_valid = 4'b0001;
    repeat (3) run_cycle();
    req_valid = 4'b1001; rst = 1'b1;
    run_cycle();
    chk("midrst_inflight_before", s_inflight, 3);
    chk("midrst_req_ready", s_req_ready, 4'b0000);
    rst = 1'b0;
    run_cycle();
    chk("midrst_inflight", s_inflight, 0);
    chk("midrst_grant0", s_req_ready, 4'b0001);
    drain(6);

    // randomized traffic against the reference model
    for (int t = 0; t < 600; t++) begin
      req_data       = {$urandom, $urandom, $urandom, $urandom};
      req_valid      = 4'($urandom);
      isqrt_in_ready = ($urandom_range(0, 3) != 0);
      resp_ready     = 4'($urandom) | 4'($urandom);
      rst            = ($urandom_range(0, 99) == 0);
      run_cycle();
    end
    rst = 1'b0;
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
